// File: rtl/poly_addsub_stream.sv
// Streaming Kyber polynomial add/sub: LANES coefficients per beat, 1-deep output register.
// Define KYBER_ADD_REDUCE_EN to fully reduce every result into [0, Q).
module poly_addsub_stream #(
  parameter int WIDTH = 12,
  parameter int N     = 256,
  parameter int LANES = 8,
  parameter int Q     = 3329
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH-1:0]       a_in,
  input  logic [LANES*WIDTH-1:0]       b_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*(WIDTH+1)-1:0]   r_out,
  output logic                         out_last,
  output logic                         done
);
  localparam int BEATS = N / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam int RW = WIDTH + 1;
  localparam int SW = WIDTH + 2;
  localparam logic [SW-1:0] Q_S = SW'(Q);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  function automatic logic [RW-1:0] reduce_q(input logic [SW-1:0] s);
`ifdef KYBER_ADD_REDUCE_EN
    logic [SW-1:0] t;
    t = (s >= Q_S) ? (s - Q_S) : s;
    return t[RW-1:0];
`else
    return s[RW-1:0];
`endif
  endfunction

  // Subtraction adds Q so valid inputs never go negative in the WIDTH+2 bit sum.
  function automatic logic [RW-1:0] lane_calc(input logic             sub,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [SW-1:0] s;
    s = sub ? ({2'b00, a} - {2'b00, b} + Q_S) : ({2'b00, a} + {2'b00, b});
    return reduce_q(s);
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    beat_in_q, beat_in_d;
  logic [CNT_W-1:0]    beat_out_q, beat_out_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;
  logic                vld_p1_q, vld_p1_d;
  logic [LANES*RW-1:0] r_p1_q, r_p1_d;
  logic                in_fire, out_fire, last_beat_out;

  assign in_ready      = (state_q == RUN) && (!vld_p1_q || out_ready);
  assign in_fire       = in_valid && in_ready;
  assign out_fire      = vld_p1_q && out_ready;
  assign last_beat_out = (beat_out_q == LAST_BEAT);
  assign out_valid     = vld_p1_q;
  assign out_last      = vld_p1_q && last_beat_out;
  assign r_out         = vld_p1_q ? r_p1_q : '0;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  always_comb begin
    state_d    = state_q;
    beat_in_d  = beat_in_q;
    beat_out_d = beat_out_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    if (out_fire) begin
      beat_out_d = beat_out_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        // A start coincident with done is deliberately left for the next IDLE cycle.
        if (start && !done_q) begin
          state_d    = RUN;
          beat_in_d  = '0;
          beat_out_d = '0;
          mode_d     = mode;
        end
      end
      RUN: begin
        if (in_fire) begin
          beat_in_d = beat_in_q + 1'b1;
          if (beat_in_q == LAST_BEAT) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_fire && last_beat_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: per-lane add/sub with optional reduction into the output slot.
  always_comb begin
    r_p1_d   = r_p1_q;
    vld_p1_d = vld_p1_q;
    if (in_fire) begin
      vld_p1_d = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        r_p1_d[k*RW +: RW] = lane_calc(mode_q, a_in[k*WIDTH +: WIDTH], b_in[k*WIDTH +: WIDTH]);
      end
    end else if (out_fire) begin
      vld_p1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_in_q  <= '0;
      beat_out_q <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_in_q  <= beat_in_d;
      beat_out_q <= beat_out_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    r_p1_q <= r_p1_d;
  end

endmodule

// File: tb/tb_poly_addsub_stream.sv
// Bench for poly_addsub_stream: directed polynomials checked against a modular-arithmetic scoreboard.
module tb_poly_addsub_stream;
  localparam int W     = 12;
  localparam int NN    = 256;
  localparam int L     = 8;
  localparam int QQ    = 3329;
  localparam int BEATS = NN / L;
  localparam int RW    = W + 1;
`ifdef KYBER_ADD_REDUCE_EN
  localparam bit RED = 1'b1;
`else
  localparam bit RED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, mode, busy, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [L*W-1:0]  a_in, b_in;
  logic [L*RW-1:0] r_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  poly_addsub_stream #(.WIDTH(W), .N(NN), .LANES(L), .Q(QQ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .r_out(r_out),
    .out_last(out_last), .done(done)
  );

  typedef struct packed {
    logic [L*RW-1:0] r;
    logic            last;
  } beat_t;

  beat_t           exp_q[$];
  beat_t           e_out, e_in;
  bit              tb_mode;
  int              in_cnt_m, out_cnt_m;
  bit              done_due, stall_prev;
  logic [L*RW-1:0] r_prev, cap_r0;
  logic            last_prev;
  int              a_mem[NN];
  int              b_mem[NN];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference per coefficient: plain integer arithmetic, reduced with % when reduction is built in.
  function automatic int lane_model(input bit m, input int a, input int b);
    int s;
    s = m ? (a - b + QQ) : (a + b);
    if (RED) s = s % QQ;
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      in_cnt_m   = 0;
      out_cnt_m  = 0;
      done_due   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("done", done, done_due);
      if (done_due) chk("busy_at_done", busy, 0);
      done_due = 1'b0;
      if (stall_prev && out_valid) begin
        chk("hold_r_out", r_out, r_prev);
        chk("hold_out_last", out_last, last_prev);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e_out = exp_q.pop_front();
          chk("r_out", r_out, e_out.r);
          chk("out_last", out_last, e_out.last);
          if (out_cnt_m % BEATS == 0) cap_r0 = r_out;
          if (e_out.last) done_due = 1'b1;
          out_cnt_m++;
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < L; k++) begin
          e_in.r[k*RW +: RW] = RW'(lane_model(tb_mode, int'(a_in[k*W +: W]), int'(b_in[k*W +: W])));
        end
        e_in.last = ((in_cnt_m % BEATS) == BEATS - 1);
        in_cnt_m++;
        exp_q.push_back(e_in);
      end
      stall_prev = out_valid && !out_ready;
      r_prev     = r_out;
      last_prev  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_r_out"}, r_out, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_poly(input bit m, input int seed, input int bp_at, input int st_at,
                          input int ab_at, input bit chain);
    bit acc;
    bit seen;
    int stall;
    for (int i = 0; i < NN; i++) begin
      a_mem[i] = (i * 37 + seed * 113 + 11) % QQ;
      b_mem[i] = (i * 101 + seed * 59 + 7) % QQ;
    end
    if (!m) begin
      a_mem[0] = 3000; b_mem[0] = 500;
      a_mem[1] = 0;    b_mem[1] = 0;
      a_mem[2] = 3328; b_mem[2] = 1;
    end else begin
      a_mem[0] = 5;    b_mem[0] = 10;
      a_mem[1] = 10;   b_mem[1] = 5;
      a_mem[2] = 1234; b_mem[2] = 1234;
    end
    tb_mode = m;
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = ~m;
    chk("busy_after_start", busy, 1);
    for (int bt = 0; bt < BEATS; bt++) begin
      if (bt == ab_at) begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_reset("abort");
        rst_n = 1'b1;
        return;
      end
      for (int k = 0; k < L; k++) begin
        a_in[k*W +: W] = W'(a_mem[bt*L + k]);
        b_in[k*W +: W] = W'(b_mem[bt*L + k]);
      end
      in_valid = 1'b1;
      if (bt == st_at) begin
        start = 1'b1;
        mode  = ~m;
      end
      out_ready = (bt == bp_at) ? 1'b0 : 1'b1;
      acc   = 1'b0;
      stall = 0;
      for (int c = 0; c < 100 && !acc; c++) begin
        @(negedge clk);
        acc = in_ready;
        tick();
        if (!acc && !out_ready) begin
          stall++;
          if (stall >= 3) out_ready = 1'b1;
        end
      end
      start = 1'b0;
      if (!acc) chk("accept_timeout", acc, 1);
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = done;
      if (!seen) tick();
    end
    if (!seen) chk("done_timeout", seen, 1);
    chk("queue_drained", exp_q.size(), 0);
    if (chain) begin
      start = 1'b1;
      mode  = 1'b1;
      tick();
      chk("start_with_done_ignored", busy, 0);
      tick();
      chk("start_next_idle_taken", busy, 1);
      start    = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
    end else begin
      tick();
    end
    if (!m) begin
      chk("lit_add_3000_500", cap_r0[0 +: RW], RED ? 171 : 3500);
      chk("lit_add_0_0", cap_r0[RW +: RW], 0);
      chk("lit_add_3328_1", cap_r0[2*RW +: RW], RED ? 0 : 3329);
    end else begin
      chk("lit_sub_5_10", cap_r0[0 +: RW], 3324);
      chk("lit_sub_10_5", cap_r0[RW +: RW], RED ? 5 : 3334);
      chk("lit_sub_1234_1234", cap_r0[2*RW +: RW], RED ? 0 : 3329);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; tb_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    chk("model_add_3000_500", lane_model(1'b0, 3000, 500), RED ? 171 : 3500);
    chk("model_add_3328_1", lane_model(1'b0, 3328, 1), RED ? 0 : 3329);
    chk("model_sub_5_10", lane_model(1'b1, 5, 10), 3324);
    chk("model_sub_10_5", lane_model(1'b1, 10, 5), RED ? 5 : 3334);
    run_poly(1'b0, 1, -1, -1, -1, 1'b0);
    run_poly(1'b1, 2, 12, 20, -1, 1'b0);
    run_poly(1'b0, 3, -1, -1, 10, 1'b0);
    run_poly(1'b1, 4, -1, -1, -1, 1'b1);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_addsub_stream.md
# poly_addsub_stream

Streaming Kyber polynomial add/subtract unit. It supersedes the combinational `add`, which returns unreduced `KYBER_POLY_WIDTH+1`-bit sums for all `KYBER_N` coefficients at once. This block processes a polynomial as `KYBER_N/LANES` beats under valid/ready handshakes and supports a runtime add/sub mode with modular reduction by q. It sits between the NTT/poly-multiply datapath and the encode stage.

## Interface
- `WIDTH`, default `KYBER_POLY_WIDTH` (12): coefficient width.
- `N`, default `KYBER_N` (256): coefficients per polynomial.
- `LANES`, default 8: coefficients per beat. Must divide N and be a power of two.
- `Q`, default 3329: modulus. Must satisfy Q < 2^WIDTH.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: begin a polynomial. Sampled only in IDLE.
- `mode`, input, 1: 0 = a+b, 1 = a−b. Latched on the accepted `start`.
- `busy`, output, 1: high in RUN and FLUSH.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: input beat accepted when `in_valid` and `in_ready` are both high.
- `a_in`, input, LANES*WIDTH: lane k is at `[k*WIDTH +: WIDTH]`.
- `b_in`, input, LANES*WIDTH: same lane packing as `a_in`.
- `out_valid`, output, 1: result beat valid.
- `out_ready`, input, 1: downstream accepts the result beat.
- `r_out`, output, LANES*(WIDTH+1): lane k is at `[k*(WIDTH+1) +: WIDTH+1]`.
- `out_last`, output, 1: high with the final beat of the polynomial.
- `done`, output, 1: one-cycle pulse after the final output handshake.

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN on `start`. This clears the input counter `beat_in` (log2(N/LANES) bits) and the output counter `beat_out`, and latches `mode`.
  - RUN → FLUSH when the beat with `beat_in = N/LANES−1` is accepted.
  - FLUSH → IDLE on the output handshake where `out_last` = 1.
- `start` is ignored in RUN and FLUSH.
- `in_ready = (state==RUN) && (!out_valid || out_ready)`. The output register acts as a 1-deep pipeline stage with no bubble under continuous flow.
- Per-lane arithmetic:
  - add: `s = a + b` (WIDTH+1 bits).
  - sub: `s = a − b + Q`, evaluated in WIDTH+2 bits.
- Reduction with `KYBER_ADD_REDUCE_EN` defined: if `s ≥ Q`, then `s = s − Q`. The MSB of each lane is 0.
- Inputs must be < Q. Behaviour for inputs ≥ Q is unspecified except that no X is propagated.
- `out_last` is asserted when `beat_out = N/LANES−1`. `beat_out` increments on each output handshake.
- `done` rises in the cycle after the final output handshake and lasts one cycle, coincident with the return to IDLE.

## Timing
- Reset values: `busy`=0, `in_ready`=0, `out_valid`=0, `r_out`=0, `out_last`=0, `done`=0. State is IDLE and both counters are 0.
- Reset asserted mid-operation aborts the polynomial. No `done` is produced and in-flight data is discarded.
- Latency: 1 cycle from an input handshake to the corresponding `out_valid`.
- Throughput: 1 beat per cycle when `out_ready` is held high. A full polynomial takes N/LANES+1 cycles from the first accept to the final `out_valid`.
- When `out_valid`=1 and `out_ready`=0: `r_out` and `out_last` hold stable and `in_ready`=0.
- An input accept and an output handshake in the same cycle are both honoured, with the new data replacing the old.
- `start` asserted in the same cycle as `done` is ignored. It is sampled in the following IDLE cycle.

## Configuration
- `KYBER_ADD_REDUCE_EN` defined: results are fully reduced into [0, Q).
- Not defined:
  - add mode outputs the raw WIDTH+1-bit sum, bit-compatible with the legacy `add`.
  - sub mode outputs `a − b + Q`, truncated to WIDTH+1 bits (always < 2Q).
  - No compare/subtract logic is instantiated.

## Test plan
- Reduce on, add: lane values a=3000, b=500 → r=171. With a=0, b=0 → r=0. With a=3328, b=1 → r=0.
- Reduce on, sub: a=5, b=10 → r=3324. With a=10, b=5 → r=5. With a=b=1234 → r=0.
- Full polynomial with LANES=8 and `out_ready` held high: 32 beats, `out_last` on the 32nd beat only, `done` pulses exactly once, `busy` drops in the same cycle as the `done` pulse.
- Backpressure: hold `out_ready`=0 for 3 cycles mid-stream → `r_out` stable, `in_ready`=0, no beats lost or duplicated. Compare all 256 coefficients against a reference model.
- `start` pulsed during RUN → ignored: no counter reset, and `mode` is unchanged.
- Reset asserted at beat 10 → all outputs at reset values on the next edge. A new `start` then completes a clean 32-beat run.
- Reduce off: a=3000, b=500 add → r=3500. Sub with a=5, b=10 → r=3324.
